// File: rtl/alu_mdu_if.sv
// Handshake and operand bundle between the execute stage and the iterative
// RV32M multiply/divide unit.
interface alu_mdu_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            kill;
  logic [2:0]      sel;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] out;

  modport master (
    output start, kill, sel, a, b,
    input  busy, done, out
  );

  modport slave (
    input  start, kill, sel, a, b,
    output busy, done, out
  );
endinterface

// File: rtl/alu_mdu.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply and
// restoring divide on operand magnitudes, sign-corrected in a final cycle.
module alu_mdu #(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rst,
  alu_mdu_if.slave mdu
);

  localparam int CNT_W = $clog2(XLEN);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(XLEN - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       sel_q, sel_d;
  logic [XLEN-1:0]  ma_q, ma_d;
  logic [XLEN-1:0]  mb_q, mb_d;
  logic             neg_q, neg_d;
  logic             negr_q, negr_d;
  logic [XLEN-1:0]  hi_q, hi_d;
  logic [XLEN-1:0]  lo_q, lo_d;
  logic [XLEN-1:0]  out_q, out_d;
  logic             done_q, done_d;

  logic             a_signed, b_signed;
  logic             sign_a, sign_b;
  logic [XLEN-1:0]  mag_a, mag_b;
  logic             is_div;
  logic             div_zero, div_ovf;

  logic [XLEN:0]    mul_sum;
  logic [XLEN:0]    div_shift;
  logic [XLEN:0]    div_diff;

  logic [2*XLEN-1:0] prod_raw, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  logic [XLEN-1:0]   result;

  // Operand decode at acceptance: signedness comes only from the op code.
  always_comb begin
    a_signed = (mdu.sel == OP_MUL) || (mdu.sel == OP_MULH) || (mdu.sel == OP_MULHSU) ||
               (mdu.sel == OP_DIV) || (mdu.sel == OP_REM);
    b_signed = (mdu.sel == OP_MUL) || (mdu.sel == OP_MULH) ||
               (mdu.sel == OP_DIV) || (mdu.sel == OP_REM);
    sign_a   = a_signed & mdu.a[XLEN-1];
    sign_b   = b_signed & mdu.b[XLEN-1];
    mag_a    = sign_a ? (~mdu.a + 1'b1) : mdu.a;
    mag_b    = sign_b ? (~mdu.b + 1'b1) : mdu.b;
    is_div   = mdu.sel[2];
    div_zero = (mdu.b == '0);
    div_ovf  = ((mdu.sel == OP_DIV) || (mdu.sel == OP_REM)) &&
               (mdu.a == MIN_INT) && (mdu.b == ALL_ONES);
  end

  // One iteration step: hi:lo is the running product for multiply,
  // and remainder:quotient for divide.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, ma_q} : {(XLEN+1){1'b0}});
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, mb_q};
  end

  always_comb begin
    prod_raw = {hi_q, lo_q};
    prod_fix = neg_q ? (~prod_raw + 1'b1) : prod_raw;
    quo_fix  = neg_q ? (~lo_q + 1'b1) : lo_q;
    rem_fix  = negr_q ? (~hi_q + 1'b1) : hi_q;
    case (sel_q)
      OP_MUL:                      result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             result = quo_fix;
      default:                     result = rem_fix;
    endcase
  end

  // Fast-path results are preloaded into lo (quotient) and hi (remainder)
  // with sign flags cleared, so FIN passes them through untouched.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    neg_d   = neg_q;
    negr_d  = negr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    out_d   = out_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mdu.start && !mdu.kill) begin
          sel_d = mdu.sel;
          ma_d  = mag_a;
          mb_d  = mag_b;
          cnt_d = '0;
          if (is_div && div_zero) begin
            neg_d   = 1'b0;
            negr_d  = 1'b0;
            lo_d    = ALL_ONES;
            hi_d    = mdu.a;
            state_d = FIN;
          end else if (div_ovf) begin
            neg_d   = 1'b0;
            negr_d  = 1'b0;
            lo_d    = MIN_INT;
            hi_d    = '0;
            state_d = FIN;
          end else begin
            neg_d   = sign_a ^ sign_b;
            negr_d  = sign_a;
            hi_d    = '0;
            lo_d    = is_div ? mag_a : mag_b;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (mdu.kill) begin
          state_d = IDLE;
        end else begin
          if (sel_q[2]) begin
            if (!div_diff[XLEN]) begin
              hi_d = div_diff[XLEN-1:0];
            end else begin
              hi_d = div_shift[XLEN-1:0];
            end
            lo_d = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
          end else begin
            hi_d = mul_sum[XLEN:1];
            lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_IT) begin
            state_d = FIN;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
        if (!mdu.kill) begin
          out_d  = result;
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      neg_q   <= 1'b0;
      negr_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      neg_q   <= neg_d;
      negr_q  <= negr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign mdu.busy = (state_q != IDLE);
  assign mdu.done = done_q;
  assign mdu.out  = out_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: directed ops push expected results and issue
// edges; a monitor pops and compares on every done pulse.
module tb_alu_mdu;

  localparam logic [2:0] MUL    = 3'd0;
  localparam logic [2:0] MULH   = 3'd1;
  localparam logic [2:0] MULHSU = 3'd2;
  localparam logic [2:0] MULHU  = 3'd3;
  localparam logic [2:0] DIV    = 3'd4;
  localparam logic [2:0] DIVU   = 3'd5;
  localparam logic [2:0] REM    = 3'd6;
  localparam logic [2:0] REMU   = 3'd7;

  // Edges from the accepting start edge to the edge that raises done.
  localparam int LAT_NORMAL = 33;
  localparam int LAT_FAST   = 1;

  localparam logic [31:0] OPA = 32'hA0701581;

  logic clk = 1'b0;
  logic rst;

  alu_mdu_if #(.XLEN(32)) mduBus ();

  alu_mdu #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .mdu (mduBus)
  );

  initial forever #5 clk = ~clk;

  int cycleCount = 0;
  int checks     = 0;
  int failures   = 0;

  logic [31:0] expResQ[$];
  int          expIssueQ[$];
  int          expLatQ[$];
  string       expNameQ[$];

  initial forever begin
    @(posedge clk);
    cycleCount++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic issueRaw(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
    mduBus.sel   = sel;
    mduBus.a     = a;
    mduBus.b     = b;
    mduBus.start = 1'b1;
    @(negedge clk);
    mduBus.start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expected, input int latency, input string name);
    expResQ.push_back(expected);
    expIssueQ.push_back(cycleCount + 1);
    expLatQ.push_back(latency);
    expNameQ.push_back(name);
    issueRaw(sel, a, b);
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while ((mduBus.busy || mduBus.done || expResQ.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s timeout: busy=%0b pending=%0d required idle", name, mduBus.busy, expResQ.size());
      expResQ.delete();
      expIssueQ.delete();
      expLatQ.delete();
      expNameQ.delete();
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial forever begin
    @(posedge clk);
    #1;
    if (mduBus.done === 1'b1) begin
      if (expResQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected done: out=0x%08h with no operation outstanding", mduBus.out);
      end else begin
        logic [31:0] expRes;
        int          issue, lat;
        string       name;
        expRes = expResQ.pop_front();
        issue  = expIssueQ.pop_front();
        lat    = expLatQ.pop_front();
        name   = expNameQ.pop_front();
        checkOutput(name, mduBus.out, expRes);
        checkOutput({name, " latency"}, 32'(cycleCount - issue), 32'(lat));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int firstEdge;
    rst          = 1'b1;
    mduBus.start = 1'b0;
    mduBus.kill  = 1'b0;
    mduBus.sel   = '0;
    mduBus.a     = '0;
    mduBus.b     = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset busy", 32'(mduBus.busy), 32'd0);
    checkOutput("reset done", 32'(mduBus.done), 32'd0);
    checkOutput("reset out", mduBus.out, 32'd0);

    // Give out a nonzero value, then reset mid-CALC.
    applyStimulus(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT_NORMAL, "mulhu ones pre-reset");
    waitIdle("mulhu ones pre-reset");
    issueRaw(MUL, OPA, 32'd5);
    repeat (8) @(negedge clk);
    checkOutput("busy mid calc", 32'(mduBus.busy), 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("mid-op reset busy", 32'(mduBus.busy), 32'd0);
    checkOutput("mid-op reset done", 32'(mduBus.done), 32'd0);
    checkOutput("mid-op reset out", mduBus.out, 32'd0);
    @(negedge clk);

    applyStimulus(MUL,    OPA, 32'd5, 32'h22306B85, LAT_NORMAL, "mul");
    waitIdle("mul");
    applyStimulus(MULHU,  OPA, 32'd5, 32'h00000003, LAT_NORMAL, "mulhu");
    waitIdle("mulhu");
    applyStimulus(MULH,   OPA, 32'd5, 32'hFFFFFFFE, LAT_NORMAL, "mulh");
    waitIdle("mulh");
    applyStimulus(MULHSU, OPA, 32'd5, 32'hFFFFFFFE, LAT_NORMAL, "mulhsu");
    waitIdle("mulhsu");
    applyStimulus(DIVU,   OPA, 32'd5, 32'h20166AB3, LAT_NORMAL, "divu");
    waitIdle("divu");
    applyStimulus(REMU,   OPA, 32'd5, 32'h00000002, LAT_NORMAL, "remu");
    waitIdle("remu");
    applyStimulus(DIV,    OPA, 32'd5, 32'hECE33781, LAT_NORMAL, "div");
    waitIdle("div");
    applyStimulus(REM,    OPA, 32'd5, 32'hFFFFFFFC, LAT_NORMAL, "rem");
    waitIdle("rem");

    applyStimulus(MULH, 32'h80000000, 32'h80000000, 32'h40000000, LAT_NORMAL, "mulh min*min");
    waitIdle("mulh min*min");
    applyStimulus(DIV, 32'h80000000, 32'd2, 32'hC0000000, LAT_NORMAL, "div min/2");
    waitIdle("div min/2");
    applyStimulus(DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, LAT_NORMAL, "div 7/-2");
    waitIdle("div 7/-2");
    applyStimulus(REM, 32'd7, 32'hFFFFFFFE, 32'h00000001, LAT_NORMAL, "rem 7%-2");
    waitIdle("rem 7%-2");
    applyStimulus(REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, LAT_NORMAL, "rem -7%2");
    waitIdle("rem -7%2");

    applyStimulus(DIVU, 32'h12345678, 32'd0, 32'hFFFFFFFF, LAT_FAST, "divu by zero");
    waitIdle("divu by zero");
    applyStimulus(REMU, 32'h12345678, 32'd0, 32'h12345678, LAT_FAST, "remu by zero");
    waitIdle("remu by zero");
    applyStimulus(DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, LAT_FAST, "div by zero");
    waitIdle("div by zero");
    applyStimulus(REM, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, LAT_FAST, "rem by zero");
    waitIdle("rem by zero");
    applyStimulus(DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT_FAST, "div overflow");
    waitIdle("div overflow");
    applyStimulus(REM, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, LAT_FAST, "rem overflow");
    waitIdle("rem overflow");

    // start held high: accepts exactly every 34 edges.
    firstEdge = cycleCount + 1;
    for (int i = 0; i < 3; i++) begin
      expResQ.push_back(32'h22306B85);
      expIssueQ.push_back(firstEdge + 34 * i);
      expLatQ.push_back(LAT_NORMAL);
      expNameQ.push_back($sformatf("held start mul %0d", i));
    end
    mduBus.sel   = MUL;
    mduBus.a     = OPA;
    mduBus.b     = 32'd5;
    mduBus.start = 1'b1;
    repeat (69) @(negedge clk);
    mduBus.start = 1'b0;
    waitIdle("held start");

    // Stray start during CALC must be ignored.
    applyStimulus(DIVU, OPA, 32'd5, 32'h20166AB3, LAT_NORMAL, "divu stray start");
    repeat (9) @(negedge clk);
    issueRaw(MUL, 32'd3, 32'd3);
    checkOutput("busy after stray start", 32'(mduBus.busy), 32'd1);
    waitIdle("divu stray start");

    // Start in the done cycle is accepted.
    applyStimulus(REMU, OPA, 32'd5, 32'h00000002, LAT_NORMAL, "b2b first remu");
    n = 0;
    while (!mduBus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++;
      failures++;
      $display("[TB] FAIL b2b wait: done not seen in %0d cycles, required within 34", n);
    end
    applyStimulus(DIV, OPA, 32'd5, 32'hECE33781, LAT_NORMAL, "b2b second div");
    waitIdle("b2b second div");

    // Flush mid-divide: no done, out keeps the previous result.
    issueRaw(DIV, OPA, 32'd5);
    repeat (14) @(negedge clk);
    mduBus.kill = 1'b1;
    @(negedge clk);
    mduBus.kill = 1'b0;
    checkOutput("kill busy", 32'(mduBus.busy), 32'd0);
    checkOutput("kill done", 32'(mduBus.done), 32'd0);
    checkOutput("kill out retained", mduBus.out, 32'hECE33781);
    repeat (40) @(negedge clk);
    checkOutput("kill out still retained", mduBus.out, 32'hECE33781);

    // kill in IDLE suppresses start.
    mduBus.sel   = DIVU;
    mduBus.a     = OPA;
    mduBus.b     = 32'd5;
    mduBus.start = 1'b1;
    mduBus.kill  = 1'b1;
    @(negedge clk);
    mduBus.start = 1'b0;
    mduBus.kill  = 1'b0;
    checkOutput("kill suppresses start", 32'(mduBus.busy), 32'd0);
    repeat (3) @(negedge clk);

    applyStimulus(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT_NORMAL, "mulhu after kill");
    waitIdle("mulhu after kill");

    repeat (5) @(negedge clk);
    checkOutput("scoreboard drained", 32'(expResQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
